// File: rtl/clock_set_if.sv
// Handshake bundle between the clock-set controller and the counter
// datapath / button front end / display. The front end drives buttons and
// live counts; the controller drives tick, load, edit values, mode and blink.
interface clock_set_if;
    logic       btn_mode;
    logic       btn_inc;
    logic       btn_dec;
    logic [7:0] cur_hr;
    logic [7:0] cur_min;
    logic       sec_tick;
    logic       load;
    logic [7:0] load_hr;
    logic [7:0] load_min;
    logic [7:0] load_sec;
    logic [7:0] edit_hr;
    logic [7:0] edit_min;
    logic [1:0] mode;
    logic       blink;

    modport master (
        output btn_mode, btn_inc, btn_dec, cur_hr, cur_min,
        input  sec_tick, load, load_hr, load_min, load_sec,
               edit_hr, edit_min, mode, blink
    );

    modport slave (
        input  btn_mode, btn_inc, btn_dec, cur_hr, cur_min,
        output sec_tick, load, load_hr, load_min, load_sec,
               edit_hr, edit_min, mode, blink
    );
endinterface

// File: rtl/clock_set_ctrl.sv
// Mode/sequencing controller for an HH:MM:SS clock datapath: 1 Hz advance
// enable, button-driven hour/minute set FSM with idle timeout, one-cycle
// parallel load on commit, and a blink phase for the field being edited.
module clock_set_ctrl #(
    parameter int TICK_DIV  = 100_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int TIMEOUT_S = 30
) (
    input  logic        clk,
    input  logic        rst,
    clock_set_if.slave  bus
);

    localparam int TW = $clog2(TICK_DIV);
    localparam int BW = $clog2(BLINK_DIV);
    localparam int IW = $clog2(TIMEOUT_S + 1);

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        SET_HR  = 2'b01,
        SET_MIN = 2'b10,
        COMMIT  = 2'b11
    } mode_t;

    mode_t         state, state_n;
    logic [TW-1:0] pcnt;
    logic [BW-1:0] bcnt;
    logic [IW-1:0] idle, idle_n;
    logic [7:0]    edit_hr_q, edit_hr_n;
    logic [7:0]    edit_min_q, edit_min_n;
    logic [7:0]    load_hr_q, load_min_q;
    logic          load_q, load_n;
    logic          sec_tick_q;
    logic          blink_q;

    logic tick;
    logic btn_any;
    logic step_up;
    logic step_dn;
    logic in_set;
    logic stay_set;

    assign tick     = (pcnt == TW'(TICK_DIV - 1));
    assign btn_any  = bus.btn_mode | bus.btn_inc | bus.btn_dec;
    // inc and dec together cancel out
    assign step_up  = bus.btn_inc & ~bus.btn_dec;
    assign step_dn  = bus.btn_dec & ~bus.btn_inc;
    assign in_set   = (state == SET_HR) || (state == SET_MIN);
    // blink keeps running only while we remain in the same set mode
    assign stay_set = in_set && (state_n == state);

    // Next state, edit values, idle-seconds count and load request
    always_comb begin
        state_n    = state;
        edit_hr_n  = edit_hr_q;
        edit_min_n = edit_min_q;
        idle_n     = idle;
        load_n     = 1'b0;
        case (state)
            RUN: begin
                if (bus.btn_mode) begin
                    state_n    = SET_HR;
                    edit_hr_n  = (bus.cur_hr  > 8'd23) ? 8'd0 : bus.cur_hr;
                    edit_min_n = (bus.cur_min > 8'd59) ? 8'd0 : bus.cur_min;
                    idle_n     = '0;
                end
            end
            SET_HR: begin
                if (bus.btn_mode)
                    state_n = SET_MIN;
                else if (step_up)
                    edit_hr_n = (edit_hr_q == 8'd23) ? 8'd0 : edit_hr_q + 8'd1;
                else if (step_dn)
                    edit_hr_n = (edit_hr_q == 8'd0) ? 8'd23 : edit_hr_q - 8'd1;
            end
            SET_MIN: begin
                if (bus.btn_mode) begin
                    state_n = COMMIT;
                    load_n  = 1'b1;
                end else if (step_up)
                    edit_min_n = (edit_min_q == 8'd59) ? 8'd0 : edit_min_q + 8'd1;
                else if (step_dn)
                    edit_min_n = (edit_min_q == 8'd0) ? 8'd59 : edit_min_q - 8'd1;
            end
            default: begin
                // COMMIT lasts one cycle and ignores buttons
                state_n = RUN;
            end
        endcase
        // Idle timeout: a button always wins over an expiring count
        if (in_set) begin
            if (btn_any)
                idle_n = '0;
            else if (tick) begin
                if (idle == IW'(TIMEOUT_S - 1)) begin
                    state_n = RUN;
                    idle_n  = '0;
                end else begin
                    idle_n = idle + IW'(1);
                end
            end
        end
    end

    // State, edit values and idle counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RUN;
            edit_hr_q  <= '0;
            edit_min_q <= '0;
            idle       <= '0;
        end else begin
            state      <= state_n;
            edit_hr_q  <= edit_hr_n;
            edit_min_q <= edit_min_n;
            idle       <= idle_n;
        end
    end

    // Seconds prescaler; a commit restarts it so the next second is full length
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pcnt <= '0;
        else if (state == COMMIT || tick)
            pcnt <= '0;
        else
            pcnt <= pcnt + TW'(1);
    end

    // Blink phase generator, restarted on every set-mode entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt    <= '0;
            blink_q <= 1'b0;
        end else if (stay_set) begin
            if (bcnt == BW'(BLINK_DIV - 1)) begin
                bcnt    <= '0;
                blink_q <= ~blink_q;
            end else begin
                bcnt <= bcnt + BW'(1);
            end
        end else begin
            bcnt    <= '0;
            blink_q <= 1'b0;
        end
    end

    // Registered strobes and load values
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_tick_q <= 1'b0;
            load_q     <= 1'b0;
            load_hr_q  <= '0;
            load_min_q <= '0;
        end else begin
            sec_tick_q <= tick && (state == RUN);
            load_q     <= load_n;
            if (load_n) begin
                load_hr_q  <= edit_hr_q;
                load_min_q <= edit_min_q;
            end
        end
    end

    assign bus.sec_tick = sec_tick_q;
    assign bus.load     = load_q;
    assign bus.load_hr  = load_hr_q;
    assign bus.load_min = load_min_q;
    assign bus.load_sec = 8'd0;
    assign bus.edit_hr  = edit_hr_q;
    assign bus.edit_min = edit_min_q;
    assign bus.mode     = state;
    assign bus.blink    = blink_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Bench for clock_set_ctrl: a behavioural model predicts every output each
// cycle; directed sequences add literal checks on key cycles.
module tb_clock_set_ctrl;

    localparam int TD = 10;
    localparam int BD = 4;
    localparam int TO = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    clock_set_if bus();

    clock_set_ctrl #(.TICK_DIV(TD), .BLINK_DIV(BD), .TIMEOUT_S(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // mode: 0 RUN, 1 SET_HR, 2 SET_MIN, 3 COMMIT
    int m_mode, m_ehr, m_emin, m_lhr, m_lmin;
    int m_phase;   // cycles since reset or last commit
    int m_age;     // cycles since the current mode was entered
    int m_idle;    // ticks seen since last button / set entry
    bit m_load, m_sec;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_ehr = 0; m_emin = 0; m_lhr = 0; m_lmin = 0;
            m_phase = 0; m_age = 0; m_idle = 0; m_load = 0; m_sec = 0;
        end else begin
            bit tk, any;
            int old;
            tk  = (m_phase % TD) == TD - 1;
            any = bus.btn_mode || bus.btn_inc || bus.btn_dec;
            old = m_mode;
            m_sec  = tk && (old == 0);
            m_load = 0;
            case (old)
                0: if (bus.btn_mode) begin
                    m_mode = 1;
                    m_ehr  = (bus.cur_hr  <= 23) ? int'(bus.cur_hr)  : 0;
                    m_emin = (bus.cur_min <= 59) ? int'(bus.cur_min) : 0;
                    m_idle = 0;
                end
                1, 2: begin
                    if (bus.btn_mode) begin
                        m_mode = old + 1;
                        if (old == 2) begin
                            m_load = 1; m_lhr = m_ehr; m_lmin = m_emin;
                        end
                    end else if (bus.btn_inc != bus.btn_dec) begin
                        int d;
                        d = bus.btn_inc ? 1 : -1;
                        if (old == 1) m_ehr  = (m_ehr  + d + 24) % 24;
                        else          m_emin = (m_emin + d + 60) % 60;
                    end
                    if (any) m_idle = 0;
                    else if (tk) begin
                        m_idle++;
                        if (m_idle >= TO) begin m_mode = 0; m_idle = 0; end
                    end
                end
                default: m_mode = 0;
            endcase
            m_phase = (old == 3) ? 0 : m_phase + 1;
            m_age   = (m_mode != old) ? 0 : m_age + 1;
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        int eb;
        eb = (m_mode == 1 || m_mode == 2) ? (m_age / BD) % 2 : 0;
        check("cmp_mode",     int'(bus.mode),     m_mode);
        check("cmp_edit_hr",  int'(bus.edit_hr),  m_ehr);
        check("cmp_edit_min", int'(bus.edit_min), m_emin);
        check("cmp_sec_tick", int'(bus.sec_tick), int'(m_sec));
        check("cmp_load",     int'(bus.load),     int'(m_load));
        check("cmp_load_sec", int'(bus.load_sec), 0);
        check("cmp_blink",    int'(bus.blink),    eb);
        if (m_load) begin
            check("cmp_load_hr",  int'(bus.load_hr),  m_lhr);
            check("cmp_load_min", int'(bus.load_min), m_lmin);
        end
    end

    // One button pulse sampled by exactly one rising edge; returns #1 after it
    task automatic press(input bit m, input bit i, input bit d);
        @(negedge clk);
        bus.btn_mode = m; bus.btn_inc = i; bus.btn_dec = d;
        @(posedge clk); #1;
        bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_dec = 0;
    endtask

    initial begin
        bit done;
        bus.btn_mode = 0; bus.btn_inc = 0; bus.btn_dec = 0;
        bus.cur_hr = 0; bus.cur_min = 0;
        repeat (3) @(negedge clk);
        check("rst_mode",  int'(bus.mode), 0);
        check("rst_load",  int'(bus.load), 0);
        check("rst_blink", int'(bus.blink), 0);
        check("rst_tick",  int'(bus.sec_tick), 0);
        rst = 0;

        // 1: ticks at edges 10, 20, 30 after release only
        for (int c = 1; c <= 35; c++) begin
            @(posedge clk); #1;
            check("t1_sec_tick", int'(bus.sec_tick), (c % 10 == 0) ? 1 : 0);
            check("t1_load", int'(bus.load), 0);
        end

        // 2: wrap-around edits and commit
        bus.cur_hr = 23; bus.cur_min = 59;
        press(1, 0, 0);
        check("t2_cap_hr", int'(bus.edit_hr), 23);
        press(0, 1, 0);
        press(1, 0, 0);
        press(0, 0, 1);
        check("t2_edit_hr",  int'(bus.edit_hr), 0);
        check("t2_edit_min", int'(bus.edit_min), 58);
        press(1, 0, 0);
        check("t2_load",     int'(bus.load), 1);
        check("t2_load_hr",  int'(bus.load_hr), 0);
        check("t2_load_min", int'(bus.load_min), 58);
        check("t2_load_sec", int'(bus.load_sec), 0);
        check("t2_mode_c",   int'(bus.mode), 3);
        @(posedge clk); #1;
        check("t2_mode_run", int'(bus.mode), 0);
        check("t2_load_off", int'(bus.load), 0);

        // 3: dec wrap, inc+dec cancel, mode beats inc
        bus.cur_hr = 0; bus.cur_min = 10;
        press(1, 0, 0);
        press(0, 0, 1);
        check("t3_dec_wrap", int'(bus.edit_hr), 23);
        press(0, 1, 1);
        check("t3_both", int'(bus.edit_hr), 23);
        press(1, 1, 0);
        check("t3_mode_pri", int'(bus.mode), 2);
        check("t3_hr_hold",  int'(bus.edit_hr), 23);
        press(1, 0, 0);
        check("t3_load_hr",  int'(bus.load_hr), 23);
        check("t3_load_min", int'(bus.load_min), 10);
        @(posedge clk); #1;

        // 4: idle timeout with blink
        press(1, 0, 0);
        done = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (bus.mode == 2'd0) begin done = 1; break; end
            if (k == 3) check("t4_blink3", int'(bus.blink), 0);
            if (k == 4) check("t4_blink4", int'(bus.blink), 1);
            if (k == 8) check("t4_blink8", int'(bus.blink), 0);
            check("t4_no_load", int'(bus.load), 0);
            check("t4_no_tick", int'(bus.sec_tick), 0);
        end
        check("t4_timeout", int'(done), 1);
        check("t4_load_after", int'(bus.load), 0);

        // 5: reset mid SET_MIN
        bus.cur_hr = 5; bus.cur_min = 42;
        press(1, 0, 0);
        press(1, 0, 0);
        check("t5_edit_min", int'(bus.edit_min), 42);
        @(posedge clk); #2;
        rst = 1;
        #1;
        check("t5_mode",     int'(bus.mode), 0);
        check("t5_edit_min0", int'(bus.edit_min), 0);
        check("t5_edit_hr0", int'(bus.edit_hr), 0);
        check("t5_load",     int'(bus.load), 0);
        @(negedge clk);
        rst = 0;

        // 6: inc ignored in RUN, out-of-range capture
        press(0, 1, 0);
        check("t6_run_inc_mode", int'(bus.mode), 0);
        check("t6_run_inc_hr",   int'(bus.edit_hr), 0);
        bus.cur_hr = 30; bus.cur_min = 75;
        press(1, 0, 0);
        check("t6_hr_clamp",  int'(bus.edit_hr), 0);
        check("t6_min_clamp", int'(bus.edit_min), 0);
        press(0, 1, 0);
        press(1, 0, 0);
        press(1, 0, 0);
        check("t6_load_hr", int'(bus.load_hr), 1);
        repeat (25) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
